// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared constants for the DE register file and its pending-write scoreboard,
// including the WB->DE bus field layout so both ends pack/unpack identically.
package de_regfile_scoreboard_pkg;

    localparam int DBITS       = 32;
    localparam int REGWORDS    = 32;
    localparam int REGNOBITS   = 5;
    localparam int SB_CNTBITS  = 2;

    localparam int WB_BUS_BITS  = 1 + REGNOBITS + DBITS;
    localparam int WB_WR_BIT    = WB_BUS_BITS - 1;
    localparam int WB_REGNO_MSB = WB_BUS_BITS - 2;
    localparam int WB_REGNO_LSB = DBITS;
    localparam int WB_VAL_MSB   = DBITS - 1;
    localparam int WB_VAL_LSB   = 0;

    localparam logic [SB_CNTBITS-1:0] SB_CNT_MAX = {SB_CNTBITS{1'b1}};

    // A pending writer blocks a read unless it is the last one and retires now.
    function automatic logic src_hazard(
        input logic                  used,
        input logic [REGNOBITS-1:0]  regno,
        input logic [SB_CNTBITS-1:0] cnt,
        input logic                  wb_wr,
        input logic [REGNOBITS-1:0]  wb_regno
    );
        logic haz;
        haz = 1'b0;
        if (used && (regno != {REGNOBITS{1'b0}}) && (cnt != {SB_CNTBITS{1'b0}})) begin
            haz = !((cnt == SB_CNTBITS'(1)) && wb_wr && (wb_regno == regno));
        end else begin
            haz = 1'b0;
        end
        return haz;
    endfunction

endpackage

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// One pending-write counter: one increment, two decrements, clamps at 0 on
// underflow (reported combinationally) and saturates at its maximum.
module sb_counter
    import de_regfile_scoreboard_pkg::*;
#(
    parameter int CNTBITS = SB_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               dec_a_i,
    input  logic               dec_b_i,
    output logic [CNTBITS-1:0] cnt_o,
    output logic               underflow_o
);

    logic [CNTBITS-1:0] cnt_q;
    logic [CNTBITS-1:0] cnt_d;
    logic [CNTBITS:0]   up_s;
    logic [CNTBITS:0]   dn_s;
    logic [CNTBITS:0]   diff_s;

    // Net update in CNTBITS+1 bits so underflow is detectable before truncation.
    always_comb begin
        up_s        = {1'b0, cnt_q} + {{CNTBITS{1'b0}}, inc_i};
        dn_s        = {{CNTBITS{1'b0}}, dec_a_i} + {{CNTBITS{1'b0}}, dec_b_i};
        diff_s      = up_s - dn_s;
        underflow_o = 1'b0;
        cnt_d       = cnt_q;
        if (dn_s > up_s) begin
            underflow_o = 1'b1;
            cnt_d       = {CNTBITS{1'b0}};
        end else if (diff_s > {1'b0, {CNTBITS{1'b1}}}) begin
            cnt_d = {CNTBITS{1'b1}};
        end else begin
            cnt_d = diff_s[CNTBITS-1:0];
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNTBITS{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/de_regfile_scoreboard.sv
// DE-stage register file with WB bypass and a per-register pending-write
// scoreboard that stalls DE on RAW hazards and on too many in-flight writers.
module de_regfile_scoreboard
    import de_regfile_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WB_BUS_BITS-1:0] from_WB_to_DE,
    input  logic [REGNOBITS-1:0]   rs1_regno,
    input  logic [REGNOBITS-1:0]   rs2_regno,
    input  logic                   rs1_used,
    input  logic                   rs2_used,
    output logic [DBITS-1:0]       rs1_val,
    output logic [DBITS-1:0]       rs2_val,
    input  logic                   issue_valid,
    input  logic                   issue_wr_reg,
    input  logic [REGNOBITS-1:0]   issue_wregno,
    input  logic                   squash_valid,
    input  logic [REGNOBITS-1:0]   squash_wregno,
    output logic                   stall_DE,
    output logic                   sb_error
);

    logic                  wb_wr_s;
    logic [REGNOBITS-1:0]  wb_regno_s;
    logic [DBITS-1:0]      wb_val_s;
    logic [DBITS-1:0]      regs_q [REGWORDS];
    logic [SB_CNTBITS-1:0] cnt_s [REGWORDS];
    logic [REGWORDS-1:0]   underflow_s;
    logic                  haz1_s;
    logic                  haz2_s;
    logic                  dec_here_s;
    logic                  waw_s;
    logic                  issue_fire_s;
    logic                  sb_error_q;
    logic                  sb_error_d;

    assign wb_regno_s = from_WB_to_DE[WB_REGNO_MSB:WB_REGNO_LSB];
    assign wb_val_s   = from_WB_to_DE[WB_VAL_MSB:WB_VAL_LSB];
    assign wb_wr_s    = from_WB_to_DE[WB_WR_BIT] && (wb_regno_s != {REGNOBITS{1'b0}});

    // Architectural registers; entry 0 is never written and stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) begin
                regs_q[i] <= {DBITS{1'b0}};
            end
        end else if (wb_wr_s) begin
            regs_q[wb_regno_s] <= wb_val_s;
        end
    end

    // Read ports with same-cycle WB bypass.
    always_comb begin
        rs1_val = {DBITS{1'b0}};
        rs2_val = {DBITS{1'b0}};
        if (rs1_regno == {REGNOBITS{1'b0}}) begin
            rs1_val = {DBITS{1'b0}};
        end else if (wb_wr_s && (wb_regno_s == rs1_regno)) begin
            rs1_val = wb_val_s;
        end else begin
            rs1_val = regs_q[rs1_regno];
        end
        if (rs2_regno == {REGNOBITS{1'b0}}) begin
            rs2_val = {DBITS{1'b0}};
        end else if (wb_wr_s && (wb_regno_s == rs2_regno)) begin
            rs2_val = wb_val_s;
        end else begin
            rs2_val = regs_q[rs2_regno];
        end
    end

    // Hazard detection and stall; a same-cycle release of the destination lifts the WAW limit.
    always_comb begin
        haz1_s     = src_hazard(rs1_used, rs1_regno, cnt_s[rs1_regno], wb_wr_s, wb_regno_s);
        haz2_s     = src_hazard(rs2_used, rs2_regno, cnt_s[rs2_regno], wb_wr_s, wb_regno_s);
        dec_here_s = (wb_wr_s && (wb_regno_s == issue_wregno)) ||
                     (squash_valid && (squash_wregno == issue_wregno));
        waw_s      = issue_wr_reg && (issue_wregno != {REGNOBITS{1'b0}}) &&
                     (cnt_s[issue_wregno] == SB_CNT_MAX) && !dec_here_s;
        stall_DE   = issue_valid && (haz1_s || haz2_s || waw_s);
        issue_fire_s = issue_valid && !stall_DE && issue_wr_reg &&
                       (issue_wregno != {REGNOBITS{1'b0}});
    end

    assign cnt_s[0]       = {SB_CNTBITS{1'b0}};
    assign underflow_s[0] = 1'b0;

    generate
        for (genvar r = 1; r < REGWORDS; r++) begin : g_cnt
            logic inc_s;
            logic dec_wb_s;
            logic dec_sq_s;
            assign inc_s    = issue_fire_s && (issue_wregno == REGNOBITS'(r));
            assign dec_wb_s = wb_wr_s && (wb_regno_s == REGNOBITS'(r));
            assign dec_sq_s = squash_valid && (squash_wregno == REGNOBITS'(r));
            sb_counter #(.CNTBITS(SB_CNTBITS)) u_cnt (
                .clk         (clk),
                .reset       (reset),
                .inc_i       (inc_s),
                .dec_a_i     (dec_wb_s),
                .dec_b_i     (dec_sq_s),
                .cnt_o       (cnt_s[r]),
                .underflow_o (underflow_s[r])
            );
        end
    endgenerate

    assign sb_error_d = sb_error_q || (|underflow_s);

    // Sticky scoreboard error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    assign sb_error = sb_error_q;

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Directed bench for de_regfile_scoreboard: bypass, RAW/WAW stalls, squash,
// underflow flag, x0 handling and asynchronous reset.
module tb_de_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [37:0] from_WB_to_DE;
    logic [4:0]  rs1_regno;
    logic [4:0]  rs2_regno;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        issue_valid;
    logic        issue_wr_reg;
    logic [4:0]  issue_wregno;
    logic        squash_valid;
    logic [4:0]  squash_wregno;
    logic        stall_DE;
    logic        sb_error;

    int passed = 0;
    int total  = 0;

    de_regfile_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .from_WB_to_DE (from_WB_to_DE),
        .rs1_regno     (rs1_regno),
        .rs2_regno     (rs2_regno),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .issue_valid   (issue_valid),
        .issue_wr_reg  (issue_wr_reg),
        .issue_wregno  (issue_wregno),
        .squash_valid  (squash_valid),
        .squash_wregno (squash_wregno),
        .stall_DE      (stall_DE),
        .sb_error      (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        from_WB_to_DE = 38'd0;
        rs1_regno     = 5'd0;
        rs2_regno     = 5'd0;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
        issue_valid   = 1'b0;
        issue_wr_reg  = 1'b0;
        issue_wregno  = 5'd0;
        squash_valid  = 1'b0;
        squash_wregno = 5'd0;
    endtask

    task automatic issue_writer(input logic [4:0] r);
        idle();
        issue_valid  = 1'b1;
        issue_wr_reg = 1'b1;
        issue_wregno = r;
    endtask

    task automatic reader(input logic [4:0] r1, input logic [4:0] r2);
        idle();
        issue_valid = 1'b1;
        rs1_regno   = r1;
        rs1_used    = 1'b1;
        rs2_regno   = r2;
        rs2_used    = 1'b1;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        reader(5'd5, 5'd5);
        #2;
        chk("rst_rs1_val", rs1_val, 32'd0);
        chk("rst_stall", {31'd0, stall_DE}, 32'd0);
        chk("rst_sb_error", {31'd0, sb_error}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Writer to x5, then WB with same-cycle bypass
        issue_writer(5'd5);
        #1;
        chk("iss5_stall", {31'd0, stall_DE}, 32'd0);
        tick();
        reader(5'd5, 5'd0);
        from_WB_to_DE = {1'b1, 5'd5, 32'hDEADBEEF};
        #1;
        chk("byp5_val", rs1_val, 32'hDEADBEEF);
        chk("byp5_stall", {31'd0, stall_DE}, 32'd0);
        tick();
        reader(5'd5, 5'd5);
        #1;
        chk("reg5_rs1", rs1_val, 32'hDEADBEEF);
        chk("reg5_rs2", rs2_val, 32'hDEADBEEF);
        chk("reg5_stall", {31'd0, stall_DE}, 32'd0);
        tick();

        // RAW on x7 until WB releases it
        issue_writer(5'd7);
        #1;
        chk("iss7_stall", {31'd0, stall_DE}, 32'd0);
        tick();
        reader(5'd0, 5'd7);
        #1;
        chk("raw7_c1", {31'd0, stall_DE}, 32'd1);
        tick();
        chk("raw7_c2", {31'd0, stall_DE}, 32'd1);
        tick();
        from_WB_to_DE = {1'b1, 5'd7, 32'h0000_0077};
        #1;
        chk("raw7_wb_stall", {31'd0, stall_DE}, 32'd0);
        chk("raw7_wb_val", rs2_val, 32'h0000_0077);
        tick();

        // WAW limit on x3
        issue_writer(5'd3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("waw3_fill", {31'd0, stall_DE}, 32'd0);
            tick();
        end
        chk("waw3_full", {31'd0, stall_DE}, 32'd1);
        tick();
        chk("waw3_hold", {31'd0, stall_DE}, 32'd1);
        from_WB_to_DE = {1'b1, 5'd3, 32'h0000_0033};
        #1;
        chk("waw3_wb", {31'd0, stall_DE}, 32'd0);
        tick();
        from_WB_to_DE = 38'd0;
        #1;
        chk("waw3_after", {31'd0, stall_DE}, 32'd1);
        reader(5'd3, 5'd0);
        #1;
        chk("raw3_pending", {31'd0, stall_DE}, 32'd1);
        idle();
        for (int k = 0; k < 3; k++) begin
            from_WB_to_DE = {1'b1, 5'd3, 32'h0000_0030 + 32'(k)};
            tick();
        end
        reader(5'd3, 5'd0);
        #1;
        chk("drain3_stall", {31'd0, stall_DE}, 32'd0);
        chk("drain3_val", rs1_val, 32'h0000_0032);
        tick();

        // Squash releases a reservation
        issue_writer(5'd10);
        tick();
        idle();
        squash_valid  = 1'b1;
        squash_wregno = 5'd10;
        tick();
        reader(5'd10, 5'd0);
        #1;
        chk("sq10_stall", {31'd0, stall_DE}, 32'd0);
        chk("sq10_err", {31'd0, sb_error}, 32'd0);
        tick();

        // Underflow on x9
        idle();
        squash_valid  = 1'b1;
        squash_wregno = 5'd9;
        tick();
        reader(5'd9, 5'd0);
        #1;
        chk("uf9_err", {31'd0, sb_error}, 32'd1);
        chk("uf9_stall", {31'd0, stall_DE}, 32'd0);
        tick();
        tick();
        chk("uf9_sticky", {31'd0, sb_error}, 32'd1);

        // x0: dropped write, no counter, no hazard
        issue_writer(5'd0);
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        from_WB_to_DE = {1'b1, 5'd0, 32'h0000_1234};
        #1;
        chk("x0_byp_val", rs1_val, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("x0_stall", {31'd0, stall_DE}, 32'd0);
            tick();
        end
        reader(5'd0, 5'd0);
        #1;
        chk("x0_rs1", rs1_val, 32'd0);
        chk("x0_rs2", rs2_val, 32'd0);
        chk("x0_read_stall", {31'd0, stall_DE}, 32'd0);
        tick();

        // Issue + WB on x11 in the same cycle nets to an unchanged count
        issue_writer(5'd11);
        tick();
        issue_writer(5'd11);
        rs1_regno     = 5'd11;
        rs1_used      = 1'b1;
        from_WB_to_DE = {1'b1, 5'd11, 32'h0000_00AB};
        #1;
        chk("net11_stall", {31'd0, stall_DE}, 32'd0);
        chk("net11_byp", rs1_val, 32'h0000_00AB);
        tick();
        reader(5'd11, 5'd0);
        #1;
        chk("net11_pending", {31'd0, stall_DE}, 32'd1);
        chk("net11_val", rs1_val, 32'h0000_00AB);

        // Asynchronous reset mid-operation
        issue_writer(5'd12);
        tick();
        reader(5'd12, 5'd5);
        #1;
        chk("pre_rst_stall", {31'd0, stall_DE}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", {31'd0, stall_DE}, 32'd0);
        chk("mid_rst_rs2", rs2_val, 32'd0);
        chk("mid_rst_err", {31'd0, sb_error}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_stall", {31'd0, stall_DE}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
